sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Sequences the SPI byte engine to issue one SD-card SPI-mode command and collect its R1 response. It accepts a command index and 32-bit argument, then builds the 6-byte frame (start/index, argument MSB-first, CRC7/end bit). It starts a 6-byte SPI write, then polls single-byte SPI reads until it gets an R1 byte (bit7 = 0) or the poll limit runs out. It sits between the card-init/block-transfer FSMs above and spi_controller below.

Parameters:
- ADDR_W, 6, width of the SPI byte address and size buses; must match the SPI engine's address width.
- NCR_MAX, 8, maximum number of response-poll byte reads before timeout (minimum 1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command request; held until accepted.
- cmd_ready  output  1  high only in IDLE; the command is accepted on the cycle where cmd_valid && cmd_ready.
- cmd_index  input  6  SD command index (CMD0..CMD63).
- cmd_arg  input  32  command argument.
- resp_valid  output  1  one-cycle pulse; response fields are valid in this cycle.
- resp_r1  output  8  captured R1 byte; 8'hFF on timeout.
- resp_timeout  output  1  qualifies resp_valid; 1 means no R1 byte within NCR_MAX polls.
- busy  output  1  high in every state except IDLE.
- spi_start  output  1  one-cycle start pulse to the SPI engine.
- spi_op  output  1  1 = write (frame out), 0 = read (poll).
- spi_size  output  ADDR_W  last byte index of the transfer (N-1).
- spi_address  input  ADDR_W  byte index the SPI engine is currently sourcing or sinking.
- spi_data_in  output  8  frame byte selected by spi_address (combinational).
- spi_data_out  input  8  byte received by the SPI engine.
- spi_wr  input  1  pulse from the SPI engine: received byte valid on spi_data_out.
- spi_done  input  1  pulse from the SPI engine: transfer complete.

Behaviour:
- Reset (rst_n low at posedge) drives:
  - state = IDLE, cmd_ready = 1, busy = 0;
  - spi_start = 0, spi_op = 0, spi_size = 0;
  - resp_valid = 0, resp_timeout = 0, resp_r1 = 8'hFF;
  - frame registers = 0, poll counter = 0.
- Reset mid-operation abandons the transfer immediately; no resp_valid is produced. The SPI engine is reset separately.
- Frame bytes, latched on accept:
  - F0 = {2'b01, cmd_index}
  - F1..F4 = cmd_arg[31:24], [23:16], [15:8], [7:0]
  - F5 = {crc7, 1'b1}
- spi_data_in = F[spi_address] for addresses 0..5; 8'hFF for any other address.
- States:
  - IDLE: on accept, latch the frame and go to SEND.
  - SEND: assert spi_start for exactly one cycle with spi_op = 1 and spi_size = 5, then go to SEND_WAIT.
  - SEND_WAIT: wait for spi_done, then go to POLL and clear the poll counter.
  - POLL: assert spi_start for one cycle with spi_op = 0 and spi_size = 0, increment the poll counter, go to POLL_WAIT.
  - POLL_WAIT: on spi_wr, capture spi_data_out into the byte register. On spi_done, branch on the captured byte:
    - bit7 = 0: go to RESP with resp_timeout = 0.
    - otherwise, poll counter == NCR_MAX: go to RESP with resp_timeout = 1 and resp_r1 = 8'hFF.
    - otherwise: go back to POLL.
  - RESP: pulse resp_valid for one cycle, then return to IDLE. cmd_ready rises the cycle after the resp_valid pulse.
- Simultaneous spi_wr and spi_done in one cycle: use spi_data_out directly for the bit7 test.
- spi_done seen outside SEND_WAIT/POLL_WAIT is ignored. spi_wr seen outside POLL_WAIT is ignored.
- spi_start is never asserted while a transfer is outstanding.
- resp_r1 and resp_timeout hold their values until the next RESP.
- Latency: command accept to the first spi_start is 1 cycle; spi_done to the next spi_start is 1 cycle.
- Poll counter width is $clog2(NCR_MAX+1); it saturates and does not wrap.

Optional Feature:
Macro: SD_CRC7_EN.
- Defined: crc7 is computed over F0..F4 in the accept cycle.
  - Polynomial x^7 + x^3 + 1, initial value 0, MSB-first.
  - Evaluated combinationally from cmd_index/cmd_arg and registered into F5.
- Undefined: a fixed table sets F5:
  - 8'h95 if cmd_index == 0;
  - 8'h87 if cmd_index == 8;
  - 8'h01 otherwise (CRC off in SPI mode).

Test Plan:
- CMD0, arg 0; SPI model returns FF, FF, 01 → mosi frame 40 00 00 00 00 95; exactly 3 polls; resp_valid with resp_r1 = 01, resp_timeout = 0.
- CMD8, arg 32'h000001AA; first poll returns 01 → frame 48 00 00 01 AA 87; 1 poll; resp_r1 = 01.
- CMD17, arg 0, SD_CRC7_EN defined; first poll returns 00 → F5 = 8'h55; resp_r1 = 00. With the macro undefined → F5 = 8'h01.
- Every poll returns FF, NCR_MAX = 8 → exactly 8 read starts; resp_timeout = 1, resp_r1 = FF; cmd_ready high 1 cycle after resp_valid.
- rst_n low for 1 cycle during SEND_WAIT → next cycle IDLE, busy = 0, no resp_valid, no further spi_start. A new CMD0 afterwards completes normally.
- cmd_valid held high across back-to-back commands → second command accepted only after the first resp_valid pulse. Check spi_start is exactly 1 cycle wide and never high during an outstanding transfer.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD SPI-mode command frame over the SPI byte engine and polls for its R1 response.
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_index/cmd_arg latched on accept
//   resp_valid/resp_r1/resp_timeout one-cycle response pulse, R1 byte, timeout flag
//   busy                            high whenever not idle
//   spi_start/spi_op/spi_size       transfer request to the SPI engine (op 1 = write)
//   spi_address/spi_data_in         frame byte lookup for the byte the engine is sending
//   spi_data_out/spi_wr/spi_done    received byte, its strobe, and transfer completion
// Build option: SD_CRC7_EN computes a real CRC7 for the last frame byte instead of the fixed table.
module sd_cmd_sequencer #(
  parameter int ADDR_W = 6,
  parameter int NCR_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  output logic              resp_valid,
  output logic [7:0]        resp_r1,
  output logic              resp_timeout,
  output logic              busy,
  output logic              spi_start,
  output logic              spi_op,
  output logic [ADDR_W-1:0] spi_size,
  input  logic [ADDR_W-1:0] spi_address,
  output logic [7:0]        spi_data_in,
  input  logic [7:0]        spi_data_out,
  input  logic              spi_wr,
  input  logic              spi_done
);
  localparam int CW = $clog2(NCR_MAX + 1);
  typedef enum logic [2:0] {IDLE, SEND, SEND_WAIT, POLL, POLL_WAIT, RESP} state_t;
  state_t state, state_n;
  logic [7:0] frame [0:5];
  logic [CW-1:0] cnt;
  logic [7:0] rx, rx_now, crc_byte;
  logic last_poll;
`ifdef SD_CRC7_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
  assign crc_byte = {crc7({2'b01, cmd_index, cmd_arg}), 1'b1};
`else
  assign crc_byte = cmd_index == 6'd0 ? 8'h95 : cmd_index == 6'd8 ? 8'h87 : 8'h01;
`endif
  // a byte arriving together with spi_done must be judged directly, not via the register
  assign rx_now = spi_wr ? spi_data_out : rx;
  assign last_poll = cnt == CW'(NCR_MAX);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign resp_valid = state == RESP;
  assign spi_start = state == SEND || state == POLL;
  assign spi_op = state == SEND || state == SEND_WAIT;
  assign spi_size = spi_op ? ADDR_W'(5) : '0;
  assign spi_data_in = spi_address < ADDR_W'(6) ? frame[spi_address[2:0]] : 8'hFF;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = cmd_valid ? SEND : IDLE;
      SEND:      state_n = SEND_WAIT;
      SEND_WAIT: state_n = spi_done ? POLL : SEND_WAIT;
      POLL:      state_n = POLL_WAIT;
      POLL_WAIT: state_n = !spi_done ? POLL_WAIT : (!rx_now[7] || last_poll) ? RESP : POLL;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rx <= 8'hFF;
      resp_r1 <= 8'hFF;
      resp_timeout <= 1'b0;
      frame <= '{default: 8'h00};
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        frame[0] <= {2'b01, cmd_index};
        frame[1] <= cmd_arg[31:24];
        frame[2] <= cmd_arg[23:16];
        frame[3] <= cmd_arg[15:8];
        frame[4] <= cmd_arg[7:0];
        frame[5] <= crc_byte;
      end
      if (state == SEND_WAIT && spi_done) cnt <= '0;
      if (state == POLL) begin
        cnt <= last_poll ? cnt : cnt + 1'b1;
        rx <= 8'hFF;
      end
      if (state == POLL_WAIT && spi_wr) rx <= spi_data_out;
      if (state == POLL_WAIT && state_n == RESP) begin
        resp_r1 <= rx_now[7] ? 8'hFF : rx_now;
        resp_timeout <= rx_now[7];
      end
    end
  end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: table-driven scoreboard bench for sd_cmd_sequencer with a behavioural SPI engine.
module tb_sd_cmd_sequencer;
  logic clk = 0, rst_n = 0, cmd_valid = 0;
  logic [5:0] cmd_index = 0;
  logic [31:0] cmd_arg = 0;
  logic cmd_ready, resp_valid, resp_timeout, busy, spi_start, spi_op;
  logic [7:0] resp_r1, spi_data_in;
  logic [5:0] spi_size;
  logic [5:0] spi_address = 0;
  logic [7:0] spi_data_out = 8'hFF;
  logic spi_wr = 0, spi_done = 0;
  sd_cmd_sequencer #(.ADDR_W(6), .NCR_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_valid(resp_valid), .resp_r1(resp_r1),
    .resp_timeout(resp_timeout), .busy(busy), .spi_start(spi_start), .spi_op(spi_op),
    .spi_size(spi_size), .spi_address(spi_address), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_wr(spi_wr), .spi_done(spi_done)
  );
  always #5 clk = ~clk;
`ifdef SD_CRC7_EN
  localparam logic [7:0] C17 = 8'h55, C55 = 8'h65, C41 = 8'h77, C58 = 8'hFD;
`else
  localparam logic [7:0] C17 = 8'h01, C55 = 8'h01, C41 = 8'h01, C58 = 8'h01;
`endif
  int checks = 0, errors = 0;
  int rstarts = 0, wstarts = 0;
  bit same_cyc = 0;
  logic [7:0] poll_q[$];
  logic [7:0] mosi[$];
  typedef struct {
    logic [47:0] frame;
    int polls;
    logic [7:0] r1;
    logic to;
  } exp_t;
  exp_t sb[$];
  typedef struct {
    logic [5:0] idx;
    logic [31:0] arg;
    int nff;
    logic [7:0] rbyte;
    bit same;
    logic [7:0] f5;
  } rec_t;
  rec_t tbl[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // SPI engine model: serves the 6-byte write and single-byte poll reads
  initial forever begin
    @(negedge clk);
    while (spi_start === 1'b1) begin
      if (spi_op) begin
        wstarts++;
        chk("wr_size", 64'(spi_size), 64'd5);
        for (int a = 0; a < 6; a++) begin
          spi_address = 6'(a);
          @(negedge clk);
          mosi.push_back(spi_data_in);
          chk("start_while_busy", 64'(spi_start), 64'd0);
        end
        spi_address = 6'd6;
        spi_done = 1;
        @(negedge clk);
        chk("pad_byte", 64'(spi_data_in), 64'hFF);
        spi_done = 0;
      end else begin
        rstarts++;
        chk("rd_size", 64'(spi_size), 64'd0);
        @(negedge clk);
        chk("start_while_busy", 64'(spi_start), 64'd0);
        spi_data_out = poll_q.size() != 0 ? poll_q.pop_front() : 8'hFF;
        spi_wr = 1;
        if (!same_cyc) begin
          @(negedge clk);
          spi_wr = 0;
          chk("start_while_busy", 64'(spi_start), 64'd0);
        end
        spi_done = 1;
        @(negedge clk);
        spi_wr = 0;
        spi_done = 0;
      end
    end
  end
  // response monitor: pops the scoreboard on each resp_valid pulse
  initial forever begin
    exp_t e;
    logic [47:0] got;
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        got = '0;
        foreach (mosi[i]) got = {got[39:0], mosi[i]};
        chk("mosi_len", 64'(mosi.size()), 64'd6);
        chk("mosi_frame", 64'(got), 64'(e.frame));
        chk("poll_count", 64'(rstarts), 64'(e.polls));
        chk("write_count", 64'(wstarts), 64'd1);
        chk("resp_r1", 64'(resp_r1), 64'(e.r1));
        chk("resp_timeout", 64'(resp_timeout), 64'(e.to));
        chk("busy_in_resp", 64'(busy), 64'd1);
      end
      rstarts = 0;
      wstarts = 0;
      mosi.delete();
    end
  end
  task automatic push_exp(input rec_t r);
    exp_t e;
    e.frame = {2'b01, r.idx, r.arg, r.f5};
    e.polls = r.nff >= 8 ? 8 : r.nff + 1;
    e.r1 = r.nff >= 8 ? 8'hFF : r.rbyte;
    e.to = r.nff >= 8;
    sb.push_back(e);
    for (int i = 0; i < r.nff && i < 8; i++) poll_q.push_back(8'hFF);
    if (r.nff < 8) poll_q.push_back(r.rbyte);
  endtask
  task automatic wait_resp();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    if (!seen) chk("resp_wait_bound", 64'd0, 64'd1);
  endtask
  task automatic run(input rec_t r);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    same_cyc = r.same;
    cmd_index = r.idx;
    cmd_arg = r.arg;
    push_exp(r);
    cmd_valid = 1;
    @(negedge clk);
    chk("accept_to_start", 64'(spi_start), 64'd1);
    cmd_valid = 0;
    wait_resp();
    @(negedge clk);
    chk("ready_after_resp", 64'(cmd_ready), 64'd1);
    chk("resp_one_cycle", 64'(resp_valid), 64'd0);
  endtask
  initial begin
    rec_t b;
    bit bad;
    tbl[0] = '{6'd0, 32'h0, 2, 8'h01, 0, 8'h95};
    tbl[1] = '{6'd8, 32'h000001AA, 0, 8'h01, 1, 8'h87};
    tbl[2] = '{6'd17, 32'h0, 0, 8'h00, 0, C17};
    tbl[3] = '{6'd0, 32'h0, 8, 8'hFF, 0, 8'h95};
    tbl[4] = '{6'd55, 32'h0, 3, 8'h00, 1, C55};
    tbl[5] = '{6'd41, 32'h40000000, 7, 8'h05, 0, C41};
    tbl[6] = '{6'd58, 32'h0, 1, 8'h7F, 1, C58};
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(spi_start), 64'd0);
    chk("rst_op", 64'(spi_op), 64'd0);
    chk("rst_size", 64'(spi_size), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_timeout", 64'(resp_timeout), 64'd0);
    chk("rst_r1", 64'(resp_r1), 64'hFF);
    chk("rst_frame", 64'(spi_data_in), 64'h00);
    rst_n = 1;
    @(negedge clk);
    foreach (tbl[i]) run(tbl[i]);
    // back-to-back: cmd_valid held, second command must wait for the first response
    same_cyc = 0;
    cmd_index = 6'd8;
    cmd_arg = 32'h000001AA;
    push_exp(tbl[1]);
    cmd_valid = 1;
    @(negedge clk);
    chk("b2b_start", 64'(spi_start), 64'd1);
    wait_resp();
    chk("b2b_not_ready", 64'(cmd_ready), 64'd0);
    b = '{6'd0, 32'h0, 0, 8'h00, 0, 8'h95};
    cmd_index = 6'd0;
    cmd_arg = 32'h0;
    push_exp(b);
    @(negedge clk);
    chk("b2b_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("b2b_second_start", 64'(spi_start), 64'd1);
    cmd_valid = 0;
    wait_resp();
    @(negedge clk);
    // reset during SEND_WAIT abandons the command silently
    cmd_index = 6'd0;
    cmd_arg = 32'h0;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad |= spi_start | resp_valid;
    end
    chk("reset_quiet", 64'(bad), 64'd0);
    mosi.delete();
    rstarts = 0;
    wstarts = 0;
    run(tbl[0]);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
